dump_sequencer: RTL and testbench

Debug-side controller that sequences a full processor-state dump over the debug UART after a halt or step. It captures the last PC and walks the register bank and the data memory through their debug read ports. Each 32-bit word is serialized LSB-first into bytes, with one byte handed to the UART transmitter per `tx_start`/`tx_done` handshake. It sits between the debug unit (command source), the datapath debug read ports and the UART transmitter, replacing the debug unit's ad-hoc dump logic.

---
 rtl/dump_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_dump_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dump_sequencer
// Description : Streams a debug dump (PC, register bank, data memory) to the
//               UART one byte per tx handshake, LSB first.
//               Optional macro DUMP_CHECKSUM_EN appends an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_sequencer #(
    parameter int BYTE     = 8,
    parameter int DWORD    = 32,
    parameter int RB_ADDR  = 5,
    parameter int DM_ADDR  = 5,
    parameter int RB_DEPTH = 32,
    parameter int DM_DEPTH = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [DWORD-1:0]   i_pc_value,
    input  logic [DWORD-1:0]   i_rb_data,
    input  logic [DWORD-1:0]   i_dm_data,
    input  logic               i_tx_done,
    output logic [RB_ADDR-1:0] o_rb_addr,
    output logic               o_rb_read_enable,
    output logic [DM_ADDR-1:0] o_dm_addr,
    output logic               o_dm_read_enable,
    output logic               o_dm_du_flag,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SEND    = 4'd1,
        ST_WAIT_TX = 4'd2,
        ST_RB_REQ  = 4'd3,
        ST_RB_WAIT = 4'd4,
        ST_DM_REQ  = 4'd5,
        ST_DM_WAIT = 4'd6,
`ifdef DUMP_CHECKSUM_EN
        ST_CK_SEND = 4'd7,
`endif
        ST_FINISH  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PH_PC = 2'd0,
        PH_RB = 2'd1,
        PH_DM = 2'd2,
        PH_CK = 2'd3
    } phase_t;

    // Counters carry one extra bit so DEPTH == 2**ADDR never wraps.
    localparam logic [RB_ADDR:0] c_rb_last   = (RB_ADDR+1)'(RB_DEPTH - 1);
    localparam logic [DM_ADDR:0] c_dm_last   = (DM_ADDR+1)'(DM_DEPTH - 1);
    localparam logic [RB_ADDR:0] c_rb_one    = (RB_ADDR+1)'(1);
    localparam logic [DM_ADDR:0] c_dm_one    = (DM_ADDR+1)'(1);
    localparam logic [1:0]       c_last_byte = 2'd3;

    state_t             r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [DWORD-1:0]   r_word, w_word_nxt;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [RB_ADDR:0]   r_rb_cnt, w_rb_cnt_nxt;
    logic [DM_ADDR:0]   r_dm_cnt, w_dm_cnt_nxt;
    logic [BYTE-1:0]    w_byte;
    logic [BYTE-1:0]    w_tx_data_nxt;
    logic               w_tx_start_nxt;
    logic               w_du_flag_nxt;
`ifdef DUMP_CHECKSUM_EN
    logic [BYTE-1:0]    r_ck, w_ck_nxt;
`endif

    function automatic logic [BYTE-1:0] byte_of(input logic [DWORD-1:0] word,
                                                input logic [1:0]       idx);
        case (idx)
            2'd0:    byte_of = word[BYTE-1:0];
            2'd1:    byte_of = word[2*BYTE-1:BYTE];
            2'd2:    byte_of = word[3*BYTE-1:2*BYTE];
            default: byte_of = word[4*BYTE-1:3*BYTE];
        endcase
    endfunction

    function automatic logic [RB_ADDR-1:0] rb_sat(input logic [RB_ADDR:0] cnt);
        rb_sat = cnt[RB_ADDR] ? '1 : cnt[RB_ADDR-1:0];
    endfunction

    function automatic logic [DM_ADDR-1:0] dm_sat(input logic [DM_ADDR:0] cnt);
        dm_sat = cnt[DM_ADDR] ? '1 : cnt[DM_ADDR-1:0];
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_word_nxt   = r_word;
        w_idx_nxt    = r_idx;
        w_rb_cnt_nxt = r_rb_cnt;
        w_dm_cnt_nxt = r_dm_cnt;
`ifdef DUMP_CHECKSUM_EN
        w_ck_nxt     = (r_state == ST_IDLE) ? '0 : r_ck;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_word_nxt   = i_pc_value;
                    w_idx_nxt    = 2'd0;
                    w_phase_nxt  = PH_PC;
                    w_rb_cnt_nxt = '0;
                    w_dm_cnt_nxt = '0;
                    w_state_nxt  = ST_SEND;
                end
            end
            ST_SEND: w_state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    if (r_idx != c_last_byte) begin
                        w_idx_nxt   = r_idx + 2'd1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        case (r_phase)
                            PH_PC: begin
                                w_phase_nxt  = PH_RB;
                                w_rb_cnt_nxt = '0;
                                w_state_nxt  = ST_RB_REQ;
                            end
                            PH_RB: begin
                                if (r_rb_cnt < c_rb_last) begin
                                    w_rb_cnt_nxt = r_rb_cnt + c_rb_one;
                                    w_state_nxt  = ST_RB_REQ;
                                end else begin
                                    w_phase_nxt  = PH_DM;
                                    w_dm_cnt_nxt = '0;
                                    w_state_nxt  = ST_DM_REQ;
                                end
                            end
                            PH_DM: begin
                                if (r_dm_cnt < c_dm_last) begin
                                    w_dm_cnt_nxt = r_dm_cnt + c_dm_one;
                                    w_state_nxt  = ST_DM_REQ;
                                end else begin
`ifdef DUMP_CHECKSUM_EN
                                    w_phase_nxt  = PH_CK;
                                    w_state_nxt  = ST_CK_SEND;
`else
                                    w_state_nxt  = ST_FINISH;
`endif
                                end
                            end
                            default: w_state_nxt = ST_FINISH;
                        endcase
                    end
                end
            end
            ST_RB_REQ:  w_state_nxt = ST_RB_WAIT;
            ST_RB_WAIT: begin
                w_word_nxt  = i_rb_data;
                w_idx_nxt   = 2'd0;
                w_state_nxt = ST_SEND;
            end
            ST_DM_REQ:  w_state_nxt = ST_DM_WAIT;
            ST_DM_WAIT: begin
                w_word_nxt  = i_dm_data;
                w_idx_nxt   = 2'd0;
                w_state_nxt = ST_SEND;
            end
`ifdef DUMP_CHECKSUM_EN
            // Checksum is a one-byte "word": last index so the next done finishes.
            ST_CK_SEND: begin
                w_idx_nxt   = c_last_byte;
                w_state_nxt = ST_WAIT_TX;
            end
`endif
            ST_FINISH:  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase

        w_byte         = byte_of(w_word_nxt, w_idx_nxt);
        w_tx_data_nxt  = o_tx_data;
        w_tx_start_nxt = (w_state_nxt == ST_SEND);
        if (w_state_nxt == ST_SEND) begin
            w_tx_data_nxt = w_byte;
        end
`ifdef DUMP_CHECKSUM_EN
        if (w_state_nxt == ST_SEND) begin
            w_ck_nxt = w_ck_nxt ^ w_byte;
        end
        if (w_state_nxt == ST_CK_SEND) begin
            w_tx_data_nxt  = r_ck;
            w_tx_start_nxt = 1'b1;
        end
`endif
        w_du_flag_nxt = (w_phase_nxt == PH_DM) &&
                        (w_state_nxt inside {ST_DM_REQ, ST_DM_WAIT, ST_SEND, ST_WAIT_TX});
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state          <= ST_IDLE;
            r_phase          <= PH_PC;
            r_word           <= '0;
            r_idx            <= '0;
            r_rb_cnt         <= '0;
            r_dm_cnt         <= '0;
            o_rb_addr        <= '0;
            o_rb_read_enable <= 1'b0;
            o_dm_addr        <= '0;
            o_dm_read_enable <= 1'b0;
            o_dm_du_flag     <= 1'b0;
            o_tx_data        <= '0;
            o_tx_start       <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_phase          <= w_phase_nxt;
            r_word           <= w_word_nxt;
            r_idx            <= w_idx_nxt;
            r_rb_cnt         <= w_rb_cnt_nxt;
            r_dm_cnt         <= w_dm_cnt_nxt;
            o_rb_addr        <= rb_sat(w_rb_cnt_nxt);
            o_rb_read_enable <= (w_state_nxt == ST_RB_REQ);
            o_dm_addr        <= dm_sat(w_dm_cnt_nxt);
            o_dm_read_enable <= (w_state_nxt == ST_DM_REQ);
            o_dm_du_flag     <= w_du_flag_nxt;
            o_tx_data        <= w_tx_data_nxt;
            o_tx_start       <= w_tx_start_nxt;
            o_busy           <= (w_state_nxt != ST_IDLE);
            o_done           <= (w_state_nxt == ST_FINISH);
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ck <= '0;
        end else begin
            r_ck <= w_ck_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dump_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dump_sequencer
// Description : Scoreboard bench for dump_sequencer with modelled memories and
//               a UART responder acknowledging each byte 3 cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dump_sequencer;

    localparam int N_DATA   = 4 * (1 + 32 + 32);
    localparam int DM_FIRST = 4 * (1 + 32);
    localparam int TIMEOUT  = 5000;
`ifdef DUMP_CHECKSUM_EN
    localparam int N_BYTES  = N_DATA + 1;
`else
    localparam int N_BYTES  = N_DATA;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_start, i_tx_done;
    logic [31:0] i_pc_value, i_rb_data, i_dm_data;
    logic [4:0]  o_rb_addr, o_dm_addr;
    logic        o_rb_read_enable, o_dm_read_enable, o_dm_du_flag;
    logic [7:0]  o_tx_data;
    logic        o_tx_start, o_busy, o_done;
    logic [23:0] w_outs;

    assign w_outs = {o_rb_addr, o_rb_read_enable, o_dm_addr, o_dm_read_enable,
                     o_dm_du_flag, o_tx_data, o_tx_start, o_busy, o_done};

    dump_sequencer dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_pc_value       (i_pc_value),
        .i_rb_data        (i_rb_data),
        .i_dm_data        (i_dm_data),
        .i_tx_done        (i_tx_done),
        .o_rb_addr        (o_rb_addr),
        .o_rb_read_enable (o_rb_read_enable),
        .o_dm_addr        (o_dm_addr),
        .o_dm_read_enable (o_dm_read_enable),
        .o_dm_du_flag     (o_dm_du_flag),
        .o_tx_data        (o_tx_data),
        .o_tx_start       (o_tx_start),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    int         total = 0, passed = 0, failed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ck_model;
    int         byte_count = 0, rb_pulses = 0, dm_pulses = 0, done_pulses = 0;
    int         rb_exp_addr = 0, dm_exp_addr = 0;
    int         pending = 0, cyc = 0, last_done_cyc = 0;
    bit         inject_spurious = 1'b0, rb_pend = 1'b0, dm_pend = 1'b0;
    logic [4:0] rb_pend_addr, dm_pend_addr;

    function automatic logic [31:0] rb_value(input logic [31:0] k);
        return 32'h0101_0101 * k;
    endfunction

    function automatic logic [31:0] dm_value(input logic [31:0] k);
        return 32'hA5A5_0000 + k;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            ck_model = ck_model ^ w[8*b +: 8];
        end
    endtask

    task automatic start_dump(input logic [31:0] pc);
        byte_count  = 0;
        rb_pulses   = 0;
        dm_pulses   = 0;
        done_pulses = 0;
        rb_exp_addr = 0;
        dm_exp_addr = 0;
        exp_q.delete();
        ck_model = 8'h00;
        push_word(pc);
        for (int k = 0; k < 32; k++) push_word(rb_value(32'(k)));
        for (int k = 0; k < 32; k++) push_word(dm_value(32'(k)));
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(ck_model);
`endif
        i_pc_value = pc;
        i_start    = 1'b1;
        @(negedge clk);
        i_start    = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (byte_count < n && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        check("wait_bytes_reached", 32'(byte_count >= n), 32'd1);
    endtask

    task automatic finish_dump(input string tag);
        int k = 0;
        while (done_pulses == 0 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_bytes"}, 32'(byte_count), 32'(N_BYTES));
        check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check({tag, "_rb_pulses"}, 32'(rb_pulses), 32'd32);
        check({tag, "_dm_pulses"}, 32'(dm_pulses), 32'd32);
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_after"}, 32'(o_busy), 32'd0);
    endtask

    // UART responder, memory models and output monitor.
    initial begin : monitor
        i_tx_done = 1'b0;
        i_rb_data = '0;
        i_dm_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            i_tx_done = 1'b0;
            if (!i_reset) begin
                pending = 0;
                rb_pend = 1'b0;
                dm_pend = 1'b0;
            end else begin
                if (rb_pend) begin
                    i_rb_data = rb_value(32'(rb_pend_addr));
                    rb_pend   = 1'b0;
                end
                if (dm_pend) begin
                    i_dm_data = dm_value(32'(dm_pend_addr));
                    dm_pend   = 1'b0;
                end
                if (o_rb_read_enable) begin
                    check("rb_addr", 32'(o_rb_addr), 32'(rb_exp_addr));
                    check("rb_du_flag", 32'(o_dm_du_flag), 32'd0);
                    rb_pend      = 1'b1;
                    rb_pend_addr = o_rb_addr;
                    rb_exp_addr++;
                    rb_pulses++;
                end
                if (o_dm_read_enable) begin
                    check("dm_addr", 32'(o_dm_addr), 32'(dm_exp_addr));
                    check("dm_du_flag", 32'(o_dm_du_flag), 32'd1);
                    dm_pend      = 1'b1;
                    dm_pend_addr = o_dm_addr;
                    dm_exp_addr++;
                    dm_pulses++;
                end
                if (o_tx_start) begin
                    if (exp_q.size() == 0)
                        check("byte_overrun", 32'(byte_count + 1), 32'(N_BYTES));
                    else
                        check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                    if (byte_count > 0 && byte_count < N_DATA)
                        check("tx_gap", 32'(cyc - last_done_cyc),
                              (byte_count % 4 == 0) ? 32'd3 : 32'd1);
                    check("tx_du_flag", 32'(o_dm_du_flag),
                          32'(byte_count >= DM_FIRST && byte_count < N_DATA));
                    check("tx_busy", 32'(o_busy), 32'd1);
                    byte_count++;
                    pending = 3;
                    if (inject_spurious) begin
                        i_tx_done       = 1'b1;
                        inject_spurious = 1'b0;
                    end
                end else if (pending > 0) begin
                    pending--;
                    if (pending == 0) begin
                        i_tx_done     = 1'b1;
                        last_done_cyc = cyc;
                    end
                end
                if (o_done) begin
                    done_pulses++;
                    check("done_busy", 32'(o_busy), 32'd1);
`ifndef DUMP_CHECKSUM_EN
                    check("done_latency", 32'(cyc - last_done_cyc), 32'd1);
`endif
                end
            end
        end
    end

    initial begin : stimulus
        i_start    = 1'b0;
        i_pc_value = '0;
        i_reset    = 1'b1;
        #1 i_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(w_outs), 32'd0);

        i_reset = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_no_tx", 32'(byte_count), 32'd0);

        // Full dump.
        start_dump(32'h0000_0040);
        finish_dump("full");

        // Start request and stray tx_done while busy must be ignored.
        start_dump(32'h0000_0040);
        wait_bytes(10);
        i_start         = 1'b1;
        inject_spurious = 1'b1;
        @(negedge clk);
        i_start         = 1'b0;
        finish_dump("busy_start");

        // Reset in the middle of R5, then restart from the PC.
        start_dump(32'hDEAD_BEEF);
        wait_bytes(26);
        check("mid_busy", 32'(o_busy), 32'd1);
        i_reset = 1'b0;
        #1;
        check("mid_reset_outputs", 32'(w_outs), 32'd0);
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", 32'(done_pulses), 32'd0);
        check("mid_reset_hold", 32'(w_outs), 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        start_dump(32'h8765_4321);
        finish_dump("restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
